// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU types: word, pipeline control state and stage control pair
package cpu_types_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    REDIR_WAIT = 2'd1,
    HALT       = 2'd2
  } pipe_ctrl_state_t;

  typedef struct packed {
    logic en;
    logic flush;
  } stage_ctrl_t;

  localparam stage_ctrl_t STAGE_FREEZE = '{en: 1'b0, flush: 1'b0};
  localparam stage_ctrl_t STAGE_GO     = '{en: 1'b1, flush: 1'b0};
  localparam stage_ctrl_t STAGE_BUBBLE = '{en: 1'b0, flush: 1'b1};

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with async active-low clear
module sat_counter #(
  parameter int W = 16
) (
  input  logic         CLK,
  input  logic         nRST,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  // count up on inc, hold at all-ones instead of wrapping
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - stall/flush sequencer for the 5-stage pipeline
module pipeline_ctrl
  import cpu_types_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             mem_req,
  input  logic             redirect_en,
  input  word_t            redirect_npc,
  input  logic             cancel_fetch,
  input  logic             load_use,
  input  logic             halt_req,
  output logic             pc_en,
  output logic             pc_sel_redir,
  output word_t            npc_out,
  output logic             fd_en,
  output logic             de_en,
  output logic             em_en,
  output logic             mw_en,
  output logic             fd_flush,
  output logic             de_flush,
  output logic             em_flush,
  output logic             redirect_pending,
  output logic             halted,
  output logic [CNT_W-1:0] mispredict_cnt
);

  pipe_ctrl_state_t state, next_state;
  word_t            redir_q;
  logic             capture_redir;
  logic             count_mispredict;
  logic             dstall;
  stage_ctrl_t      fd, de, em, mw;
  logic             pc_en_c, pc_sel_c, pending_c, halted_c;
  word_t            npc_c;

  assign dstall = mem_req & ~dhit;

  // decode state and hazards into latch/PC controls and the next state
  always_comb begin
    next_state       = state;
    capture_redir    = 1'b0;
    count_mispredict = 1'b0;
    fd               = STAGE_GO;
    de               = STAGE_GO;
    em               = STAGE_GO;
    mw               = STAGE_GO;
    pc_en_c          = 1'b0;
    pc_sel_c         = 1'b0;
    npc_c            = '0;
    pending_c        = 1'b0;
    halted_c         = 1'b0;
    unique case (state)
      RUN: begin
        if (halt_req) begin
          // older instruction halts; any redirect from younger ones is dropped
          {fd, de, em, mw} = {4{STAGE_FREEZE}};
          next_state       = HALT;
        end else if (dstall) begin
          // redirect and load_use sources are frozen and re-present later
          {fd, de, em, mw} = {4{STAGE_FREEZE}};
        end else if (redirect_en && ihit) begin
          pc_en_c          = 1'b1;
          pc_sel_c         = 1'b1;
          npc_c            = redirect_npc;
          fd.flush         = cancel_fetch;
          count_mispredict = cancel_fetch;
        end else if (redirect_en) begin
          fd               = STAGE_BUBBLE;
          capture_redir    = 1'b1;
          count_mispredict = cancel_fetch;
          next_state       = REDIR_WAIT;
        end else if (load_use) begin
          fd = STAGE_FREEZE;
          de = STAGE_BUBBLE;
        end else if (ihit) begin
          pc_en_c = 1'b1;
        end else begin
          fd = STAGE_BUBBLE;
        end
      end
      REDIR_WAIT: begin
        pending_c = 1'b1;
        npc_c     = redir_q;
        if (halt_req) begin
          {fd, de, em, mw} = {4{STAGE_FREEZE}};
          next_state       = HALT;
        end else if (dstall) begin
          {fd, de, em, mw} = {4{STAGE_FREEZE}};
        end else if (ihit) begin
          // the word that arrived belongs to the old path; replace it with the target
          fd         = STAGE_BUBBLE;
          pc_en_c    = 1'b1;
          pc_sel_c   = 1'b1;
          next_state = RUN;
        end else begin
          fd = STAGE_BUBBLE;
        end
      end
      default: begin
        {fd, de, em, mw} = {4{STAGE_FREEZE}};
        halted_c         = 1'b1;
        next_state       = HALT;
      end
    endcase
  end

  // state and held redirect target
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state   <= RUN;
      redir_q <= '0;
    end else begin
      state <= next_state;
      if (capture_redir) begin
        redir_q <= redirect_npc;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_mispredict_cnt (
    .CLK  (CLK),
    .nRST (nRST),
    .inc  (count_mispredict),
    .cnt  (mispredict_cnt)
  );

  // outputs are quiet while reset is held
  always_comb begin
    pc_en            = nRST & pc_en_c;
    pc_sel_redir     = nRST & pc_sel_c;
    npc_out          = nRST ? npc_c : '0;
    fd_en            = nRST & fd.en;
    de_en            = nRST & de.en;
    em_en            = nRST & em.en;
    mw_en            = nRST & mw.en;
    fd_flush         = nRST & fd.flush;
    de_flush         = nRST & de.flush;
    em_flush         = nRST & em.flush;
    redirect_pending = nRST & pending_c;
    halted           = nRST & halted_c;
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - directed self-checking bench for pipeline_ctrl
module tb_pipeline_ctrl;
  import cpu_types_pkg::*;

  localparam int CW = 3;

  logic          CLK;
  logic          nRST;
  logic          ihit, dhit, mem_req, redirect_en, cancel_fetch, load_use, halt_req;
  word_t         redirect_npc;
  logic          pc_en, pc_sel_redir;
  word_t         npc_out;
  logic          fd_en, de_en, em_en, mw_en;
  logic          fd_flush, de_flush, em_flush;
  logic          redirect_pending, halted;
  logic [CW-1:0] mispredict_cnt;

  int total = 0;
  int bad   = 0;
  int exp_cnt;

  pipeline_ctrl #(.CNT_W(CW)) dut (
    .CLK              (CLK),
    .nRST             (nRST),
    .ihit             (ihit),
    .dhit             (dhit),
    .mem_req          (mem_req),
    .redirect_en      (redirect_en),
    .redirect_npc     (redirect_npc),
    .cancel_fetch     (cancel_fetch),
    .load_use         (load_use),
    .halt_req         (halt_req),
    .pc_en            (pc_en),
    .pc_sel_redir     (pc_sel_redir),
    .npc_out          (npc_out),
    .fd_en            (fd_en),
    .de_en            (de_en),
    .em_en            (em_en),
    .mw_en            (mw_en),
    .fd_flush         (fd_flush),
    .de_flush         (de_flush),
    .em_flush         (em_flush),
    .redirect_pending (redirect_pending),
    .halted           (halted),
    .mispredict_cnt   (mispredict_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic ih, input logic dh, input logic mr, input logic re,
                       input word_t npc, input logic cf, input logic lu, input logic hr);
    ihit = ih; dhit = dh; mem_req = mr; redirect_en = re;
    redirect_npc = npc; cancel_fetch = cf; load_use = lu; halt_req = hr;
  endtask

  task automatic edge_step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    nRST = 1'b0;
    drive(1, 0, 0, 0, 32'h0, 0, 0, 0);
    @(negedge CLK);
    check("rst_pc_en", pc_en, 0);
    check("rst_fd_en", fd_en, 0);
    check("rst_halted", halted, 0);
    check("rst_npc", npc_out, 0);
    check("rst_cnt", mispredict_cnt, 0);

    edge_step();
    nRST = 1'b1;
    @(negedge CLK);
    check("run_pc_en", pc_en, 1);
    check("run_en_all", {fd_en, de_en, em_en, mw_en}, 4'hf);
    check("run_flush", {fd_flush, de_flush, em_flush}, 0);
    check("run_cnt", mispredict_cnt, 0);

    // redirect with ihit and cancel_fetch
    edge_step();
    drive(1, 0, 0, 1, 32'h40, 1, 0, 0);
    @(negedge CLK);
    check("redir_sel", pc_sel_redir, 1);
    check("redir_npc", npc_out, 32'h40);
    check("redir_fd_flush", fd_flush, 1);
    check("redir_pc_en", pc_en, 1);
    edge_step();
    drive(1, 0, 0, 0, 32'h0, 0, 0, 0);
    @(negedge CLK);
    check("redir_cnt", mispredict_cnt, 1);
    check("redir_sel_off", pc_sel_redir, 0);

    // redirect during icache miss
    edge_step();
    drive(0, 0, 0, 1, 32'h80, 0, 0, 0);
    @(negedge CLK);
    check("miss_pc_en", pc_en, 0);
    check("miss_fd_flush", fd_flush, 1);
    check("miss_pend0", redirect_pending, 0);
    edge_step();
    drive(0, 0, 0, 0, 32'h0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check("wait_pend", redirect_pending, 1);
      check("wait_npc", npc_out, 32'h80);
      check("wait_pc_en", pc_en, 0);
      edge_step();
    end
    drive(1, 0, 0, 1, 32'h999, 1, 0, 0);
    @(negedge CLK);
    check("wait_hit_pc_en", pc_en, 1);
    check("wait_hit_flush", fd_flush, 1);
    check("wait_hit_sel", pc_sel_redir, 1);
    check("wait_hit_npc", npc_out, 32'h80);
    edge_step();
    drive(1, 0, 0, 0, 32'h0, 0, 0, 0);
    @(negedge CLK);
    check("back_run_pend", redirect_pending, 0);
    check("back_run_cnt", mispredict_cnt, 1);

    // dcache stall holds off a redirect
    for (int i = 0; i < 2; i++) begin
      edge_step();
      drive(1, 0, 1, 1, 32'h100, 1, 0, 0);
      @(negedge CLK);
      check("dstall_en", {fd_en, de_en, em_en, mw_en}, 0);
      check("dstall_pc_en", pc_en, 0);
      check("dstall_flush", {fd_flush, de_flush, em_flush}, 0);
      check("dstall_cnt", mispredict_cnt, 1);
    end
    edge_step();
    drive(1, 1, 1, 1, 32'h100, 1, 0, 0);
    @(negedge CLK);
    check("dhit_sel", pc_sel_redir, 1);
    check("dhit_npc", npc_out, 32'h100);
    check("dhit_pc_en", pc_en, 1);
    edge_step();
    drive(1, 0, 0, 0, 32'h0, 0, 0, 0);
    @(negedge CLK);
    check("dhit_cnt", mispredict_cnt, 2);

    // load-use bubble
    edge_step();
    drive(1, 0, 0, 0, 32'h0, 0, 1, 0);
    @(negedge CLK);
    check("lu_pc_en", pc_en, 0);
    check("lu_fd_en", fd_en, 0);
    check("lu_de_flush", de_flush, 1);
    check("lu_em_mw_en", {em_en, mw_en}, 2'b11);

    // saturation of the counter
    exp_cnt = 2;
    for (int i = 0; i < 6; i++) begin
      edge_step();
      drive(1, 0, 0, 1, 32'h200, 1, 0, 0);
      edge_step();
      drive(1, 0, 0, 0, 32'h0, 0, 0, 0);
      if (exp_cnt < 7) exp_cnt++;
      @(negedge CLK);
      check("sat_cnt", mispredict_cnt, exp_cnt);
    end
    check("sat_final", mispredict_cnt, 7);

    // reset while waiting on a redirect
    edge_step();
    drive(0, 0, 0, 1, 32'h300, 0, 0, 0);
    edge_step();
    drive(0, 0, 0, 0, 32'h0, 0, 0, 0);
    @(negedge CLK);
    check("pre_rst_pend", redirect_pending, 1);
    nRST = 1'b0;
    #1;
    check("rst_pend", redirect_pending, 0);
    check("rst_npc2", npc_out, 0);
    check("rst_cnt2", mispredict_cnt, 0);
    edge_step();
    nRST = 1'b1;
    drive(1, 0, 0, 0, 32'h0, 0, 0, 0);
    @(negedge CLK);
    check("post_rst_pend", redirect_pending, 0);
    check("post_rst_sel", pc_sel_redir, 0);
    check("post_rst_npc", npc_out, 0);

    // halt beats a simultaneous redirect
    edge_step();
    drive(1, 0, 0, 1, 32'h40, 1, 0, 0);
    edge_step();
    drive(1, 0, 0, 1, 32'h44, 1, 0, 1);
    @(negedge CLK);
    check("halt_pc_en", pc_en, 0);
    check("halt_en", {fd_en, de_en, em_en, mw_en}, 0);
    check("halt_sel", pc_sel_redir, 0);
    edge_step();
    drive(1, 0, 0, 0, 32'h0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check("halted", halted, 1);
      check("halted_cnt", mispredict_cnt, 1);
      check("halted_en", {pc_en, fd_en, de_en, em_en, mw_en}, 0);
      edge_step();
    end
    nRST = 1'b0;
    #1;
    check("halt_rst", halted, 0);
    edge_step();
    nRST = 1'b1;
    @(negedge CLK);
    check("halt_rel", halted, 0);
    check("halt_rel_pc_en", pc_en, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
